brg_vvadd_xcel_rx_ctrl: RTL and testbench

Request handler that sits directly downstream of the VVADD accelerator's network receive stage. It consumes the decoded xcel-side request stream (CSR vs. local-memory), maintains the accelerator CSR file and go/done FSM, and arbitrates the tile's 1RW scratchpad between network requests and the compute engine. It returns exactly one response per accepted request, one cycle later.

---
 rtl/brg_vvadd_xcel_pkg.sv | 40 ++++
 rtl/brg_vvadd_xcel_csr_file.sv | 62 ++++++
 rtl/brg_vvadd_xcel_rx_ctrl.sv | 141 ++++++++++++++
 tb/tb_brg_vvadd_xcel_rx_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/brg_vvadd_xcel_pkg.sv
// Shared definitions for the VVADD accelerator request handler: CSR map,
// FSM state encoding and the packed CSR-file layout.
package brg_vvadd_xcel_pkg;

  localparam int unsigned CSR_GO          = 0;
  localparam int unsigned CSR_DONE        = 1;
  localparam int unsigned CSR_A_ADDR      = 2;
  localparam int unsigned CSR_B_ADDR      = 3;
  localparam int unsigned CSR_C_ADDR      = 4;
  localparam int unsigned CSR_SIZE        = 5;
  localparam int unsigned CSR_DRAM_ENABLE = 6;
  localparam int unsigned CSR_CYCLES      = 7;
  localparam int unsigned CSR_NUM_lp      = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef struct packed {
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic [31:0] c_addr;
    logic [31:0] size;
    logic        dram_enable;
    logic        done;
  } csr_s;

  function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/brg_vvadd_xcel_csr_file.sv
// Accelerator CSR storage: byte-masked writes, configuration write-protect
// while busy, and the combinational read mux.
module brg_vvadd_xcel_csr_file
  import brg_vvadd_xcel_pkg::*;
#(
  parameter int addr_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    wr_en_i,
  input  logic [addr_width_p-1:0] idx_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              mask_i,
  input  logic                    busy_i,
  input  logic                    done_set_i,
  input  logic                    done_clr_i,
  input  logic [31:0]             cycles_i,
  output csr_s                    csr_o,
  output logic [31:0]             rdata_o
);

  csr_s csr_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      csr_r <= '0;
    end else begin
      if (wr_en_i) begin
        case (idx_i)
          addr_width_p'(CSR_A_ADDR): if (!busy_i) csr_r.a_addr <= apply_mask(csr_r.a_addr, wdata_i, mask_i);
          addr_width_p'(CSR_B_ADDR): if (!busy_i) csr_r.b_addr <= apply_mask(csr_r.b_addr, wdata_i, mask_i);
          addr_width_p'(CSR_C_ADDR): if (!busy_i) csr_r.c_addr <= apply_mask(csr_r.c_addr, wdata_i, mask_i);
          addr_width_p'(CSR_SIZE):   if (!busy_i) csr_r.size   <= apply_mask(csr_r.size, wdata_i, mask_i);
          addr_width_p'(CSR_DRAM_ENABLE): if (mask_i[0]) csr_r.dram_enable <= wdata_i[0];
          addr_width_p'(CSR_DONE):        if (mask_i[0]) csr_r.done        <= wdata_i[0];
          default: ;
        endcase
      end
      // Later assignments win: engine completion overrides a same-cycle DONE write.
      if (done_clr_i) csr_r.done <= 1'b0;
      if (done_set_i) csr_r.done <= 1'b1;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (idx_i)
      addr_width_p'(CSR_GO):          rdata_o = {31'b0, busy_i};
      addr_width_p'(CSR_DONE):        rdata_o = {31'b0, csr_r.done};
      addr_width_p'(CSR_A_ADDR):      rdata_o = csr_r.a_addr;
      addr_width_p'(CSR_B_ADDR):      rdata_o = csr_r.b_addr;
      addr_width_p'(CSR_C_ADDR):      rdata_o = csr_r.c_addr;
      addr_width_p'(CSR_SIZE):        rdata_o = csr_r.size;
      addr_width_p'(CSR_DRAM_ENABLE): rdata_o = {31'b0, csr_r.dram_enable};
      addr_width_p'(CSR_CYCLES):      rdata_o = cycles_i;
      default:                        rdata_o = '0;
    endcase
  end

  assign csr_o = csr_r;

endmodule

// File: rtl/brg_vvadd_xcel_rx_ctrl.sv
// VVADD request handler: CSR/go-done FSM, scratchpad arbitration and the
// one-cycle response pipeline. BRG_VVADD_XCEL_RX_CTRL_CYCLES_EN adds a busy-cycle counter.
module brg_vvadd_xcel_rx_ctrl
  import brg_vvadd_xcel_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 16,
  parameter int dmem_size_p  = 1024,
  localparam int unsigned mem_aw_lp = $clog2(dmem_size_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      rx_v_i,
  input  logic                      rx_we_i,
  input  logic                      rx_is_CSR_i,
  input  logic                      rx_is_local_mem_i,
  input  logic [addr_width_p-1:0]   rx_addr_i,
  input  logic [data_width_p-1:0]   rx_wdata_i,
  input  logic [data_width_p/8-1:0] rx_mask_i,
  output logic                      rx_yumi_o,
  output logic [data_width_p-1:0]   rx_returning_data_o,
  output logic                      rx_returning_v_o,
  output logic                      mem_v_o,
  output logic                      mem_w_o,
  output logic [mem_aw_lp-1:0]      mem_addr_o,
  output logic [data_width_p-1:0]   mem_data_o,
  output logic [data_width_p/8-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]   mem_data_i,
  input  logic                      eng_mem_v_i,
  input  logic                      eng_mem_w_i,
  input  logic [mem_aw_lp-1:0]      eng_mem_addr_i,
  input  logic [data_width_p-1:0]   eng_mem_data_i,
  output logic                      go_o,
  output logic [data_width_p-1:0]   a_addr_o,
  output logic [data_width_p-1:0]   b_addr_o,
  output logic [data_width_p-1:0]   c_addr_o,
  output logic [data_width_p-1:0]   size_o,
  output logic                      dram_enable_o,
  input  logic                      eng_done_i
);

  state_e state_r, state_n;
  csr_s   csr;
  logic   csr_acc, local_acc, go_req;
  logic [31:0] csr_rdata, cycles;
  logic        resp_v_r, mem_rd_pend_r;
  logic [data_width_p-1:0] resp_data_r;

  assign csr_acc   = rx_v_i & rx_is_CSR_i;
  assign local_acc = rx_v_i & rx_is_local_mem_i & ~rx_is_CSR_i & ~eng_mem_v_i;
  assign rx_yumi_o = csr_acc | local_acc;
  assign go_req    = csr_acc & rx_we_i & (rx_addr_i == addr_width_p'(CSR_GO))
                   & rx_wdata_i[0] & rx_mask_i[0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (go_req)     state_n = BUSY;
      BUSY:    if (eng_done_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Gated by reset so a GO write presented during reset never escapes.
  always_comb begin
    go_o = 1'b0;
    case (state_r)
      IDLE:    go_o = go_req & reset_n_i;
      default: go_o = 1'b0;
    endcase
  end

`ifdef BRG_VVADD_XCEL_RX_CTRL_CYCLES_EN
  logic [31:0] cycles_r;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                              cycles_r <= '0;
    else if (go_o)                               cycles_r <= '0;
    else if (state_r == BUSY && cycles_r != '1)  cycles_r <= cycles_r + 32'd1;
  end
  assign cycles = cycles_r;
`else
  assign cycles = '0;
`endif

  brg_vvadd_xcel_csr_file #(.addr_width_p(addr_width_p)) csr_file (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .wr_en_i    (csr_acc & rx_we_i),
    .idx_i      (rx_addr_i),
    .wdata_i    (rx_wdata_i),
    .mask_i     (rx_mask_i),
    .busy_i     (state_r == BUSY),
    .done_set_i ((state_r == BUSY) & eng_done_i),
    .done_clr_i (go_o),
    .cycles_i   (cycles),
    .csr_o      (csr),
    .rdata_o    (csr_rdata)
  );

  always_comb begin
    mem_v_o    = local_acc;
    mem_w_o    = rx_we_i;
    mem_addr_o = mem_aw_lp'(rx_addr_i - addr_width_p'(dmem_size_p));
    mem_data_o = rx_wdata_i;
    mem_mask_o = rx_mask_i;
    if (eng_mem_v_i) begin
      mem_v_o    = 1'b1;
      mem_w_o    = eng_mem_w_i;
      mem_addr_o = eng_mem_addr_i;
      mem_data_o = eng_mem_data_i;
      mem_mask_o = '1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_r      <= 1'b0;
      mem_rd_pend_r <= 1'b0;
      resp_data_r   <= '0;
    end else begin
      resp_v_r      <= rx_yumi_o;
      mem_rd_pend_r <= local_acc & ~rx_we_i;
      resp_data_r   <= (csr_acc & ~rx_we_i) ? csr_rdata : '0;
    end
  end

  assign rx_returning_v_o    = resp_v_r;
  assign rx_returning_data_o = mem_rd_pend_r ? mem_data_i : resp_data_r;

  assign a_addr_o      = csr.a_addr;
  assign b_addr_o      = csr.b_addr;
  assign c_addr_o      = csr.c_addr;
  assign size_o        = csr.size;
  assign dram_enable_o = csr.dram_enable;

endmodule

// File: tb/tb_brg_vvadd_xcel_rx_ctrl.sv
// Scoreboard bench for brg_vvadd_xcel_rx_ctrl; expected CYCLES value follows
// BRG_VVADD_XCEL_RX_CTRL_CYCLES_EN.
module tb_brg_vvadd_xcel_rx_ctrl;
  import brg_vvadd_xcel_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int DS  = 1024;
  localparam int MAW = 10;

  logic clk = 0, reset_n_i = 0;
  logic rx_v_i = 0, rx_we_i = 0, rx_is_CSR_i = 0, rx_is_local_mem_i = 0;
  logic [AW-1:0] rx_addr_i = '0;
  logic [DW-1:0] rx_wdata_i = '0;
  logic [3:0]    rx_mask_i = '0;
  logic          rx_yumi_o, rx_returning_v_o;
  logic [DW-1:0] rx_returning_data_o;
  logic          mem_v_o, mem_w_o;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [3:0]    mem_mask_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          eng_mem_v_i = 0, eng_mem_w_i = 0;
  logic [MAW-1:0] eng_mem_addr_i = '0;
  logic [DW-1:0] eng_mem_data_i = '0;
  logic          go_o, dram_enable_o, eng_done_i = 0;
  logic [DW-1:0] a_addr_o, b_addr_o, c_addr_o, size_o;

  brg_vvadd_xcel_rx_ctrl #(.data_width_p(DW), .addr_width_p(AW), .dmem_size_p(DS)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .rx_v_i(rx_v_i), .rx_we_i(rx_we_i), .rx_is_CSR_i(rx_is_CSR_i),
    .rx_is_local_mem_i(rx_is_local_mem_i), .rx_addr_i(rx_addr_i),
    .rx_wdata_i(rx_wdata_i), .rx_mask_i(rx_mask_i), .rx_yumi_o(rx_yumi_o),
    .rx_returning_data_o(rx_returning_data_o), .rx_returning_v_o(rx_returning_v_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i),
    .eng_mem_v_i(eng_mem_v_i), .eng_mem_w_i(eng_mem_w_i),
    .eng_mem_addr_i(eng_mem_addr_i), .eng_mem_data_i(eng_mem_data_i),
    .go_o(go_o), .a_addr_o(a_addr_o), .b_addr_o(b_addr_o), .c_addr_o(c_addr_o),
    .size_o(size_o), .dram_enable_o(dram_enable_o), .eng_done_i(eng_done_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scratchpad model: one-cycle read latency, byte-masked writes.
  logic [DW-1:0] mem [0:DS-1];
  initial for (int i = 0; i < DS; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_v_o === 1'b1) begin
      if (mem_w_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else begin
        mem_data_i <= mem[mem_addr_o];
      end
    end
  end

  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rx_returning_v_o !== 1'b0) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_resp: got valid=%b data 0x%08h, expected no response (cycle %0d)",
                 rx_returning_v_o, rx_returning_data_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", rx_returning_data_o, e.data);
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle();
    rx_v_i = 0; rx_we_i = 0; rx_is_CSR_i = 0; rx_is_local_mem_i = 0;
  endtask

  task automatic req(input bit csr, input bit we, input logic [AW-1:0] addr,
                     input logic [31:0] wd, input logic [3:0] mask, input logic [31:0] exp,
                     output bit go_seen, output logic [MAW-1:0] maddr, output int acc_cyc);
    int budget;
    rx_v_i = 1; rx_is_CSR_i = csr; rx_is_local_mem_i = !csr; rx_we_i = we;
    rx_addr_i = addr; rx_wdata_i = wd; rx_mask_i = mask;
    budget = 0;
    @(negedge clk);
    while (rx_yumi_o !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
    acc_cyc = cyc; go_seen = go_o; maddr = mem_addr_o;
    if (rx_yumi_o !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got yumi=%b, expected 1 within 20 cycles (addr 0x%04h)", rx_yumi_o, addr);
    end else begin
      sb.push_back('{data: exp, cyc: cyc + 1});
    end
    @(posedge clk); #1;
  endtask

  bit g; logic [MAW-1:0] ma; int ac;
  task automatic csr_wr(input int idx, input logic [31:0] wd, input logic [3:0] mask);
    req(1, 1, AW'(idx), wd, mask, 32'h0, g, ma, ac);
  endtask
  task automatic csr_rd(input int idx, input logic [31:0] exp);
    req(1, 0, AW'(idx), 32'h0, 4'hF, exp, g, ma, ac);
  endtask

  int go_cyc, c0;
  logic [31:0] exp_cycles;

  initial begin
`ifdef BRG_VVADD_XCEL_RX_CTRL_CYCLES_EN
    exp_cycles = 32'd10;
`else
    exp_cycles = 32'd0;
`endif
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_v", rx_returning_v_o, 0);
    chk("rst_resp_data", rx_returning_data_o, 0);
    chk("rst_go", go_o, 0);
    chk("rst_size", size_o, 0);
    chk("rst_dram_en", dram_enable_o, 0);
    @(posedge clk); #1 reset_n_i = 1;

    // Full-mask configuration writes and read-back, back to back
    csr_wr(CSR_A_ADDR, 32'h1000, 4'hF);
    csr_wr(CSR_SIZE,   32'h40,   4'hF);
    csr_rd(CSR_A_ADDR, 32'h1000);
    csr_rd(CSR_SIZE,   32'h40);
    idle();
    chk("a_addr_o", a_addr_o, 32'h1000);
    chk("size_o", size_o, 32'h40);

    // Byte-masked write
    csr_wr(CSR_B_ADDR, 32'hAABBCCDD, 4'b0011);
    csr_rd(CSR_B_ADDR, 32'h0000CCDD);
    csr_rd(7'd20, 32'h0);
    idle();

    // GO, protected write while busy, done
    req(1, 1, AW'(CSR_GO), 32'h1, 4'hF, 32'h0, g, ma, go_cyc);
    chk("go_pulse", g, 1);
    csr_wr(CSR_SIZE, 32'h99, 4'hF);
    chk("go_one_cycle", go_o, 0);
    csr_rd(CSR_SIZE, 32'h40);
    csr_rd(CSR_GO, 32'h1);
    csr_rd(CSR_DONE, 32'h0);
    idle();
    do begin @(posedge clk); #1; end while (cyc < go_cyc + 10);
    eng_done_i = 1;
    @(posedge clk); #1 eng_done_i = 0;
    csr_rd(CSR_DONE, 32'h1);
    csr_rd(CSR_GO, 32'h0);
    csr_rd(CSR_CYCLES, exp_cycles);
    csr_wr(CSR_CYCLES, 32'h5555, 4'hF);
    csr_rd(CSR_CYCLES, exp_cycles);
    idle();

    // eng_done beats a same-cycle DONE clear
    csr_wr(CSR_GO, 32'h1, 4'hF);
    eng_done_i = 1;
    csr_wr(CSR_DONE, 32'h0, 4'hF);
    eng_done_i = 0;
    csr_rd(CSR_DONE, 32'h1);
    csr_rd(CSR_GO, 32'h0);
    csr_wr(CSR_DONE, 32'h0, 4'hF);
    csr_rd(CSR_DONE, 32'h0);
    csr_wr(CSR_DRAM_ENABLE, 32'h1, 4'hF);
    idle();
    chk("dram_enable_o", dram_enable_o, 1);

    // Local memory write then read
    req(0, 1, AW'(DS + 5), 32'h1234, 4'hF, 32'h0, g, ma, ac);
    chk("mem_addr_wr", ma, 5);
    req(0, 0, AW'(DS + 5), 32'h0, 4'hF, 32'h1234, g, ma, ac);
    chk("mem_addr_rd", ma, 5);
    idle();

    // Engine holds the scratchpad for 3 cycles
    rx_v_i = 1; rx_is_local_mem_i = 1; rx_we_i = 0; rx_addr_i = AW'(DS + 5);
    eng_mem_v_i = 1; eng_mem_addr_i = '0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_yumi", rx_yumi_o, 0);
      @(posedge clk); #1;
    end
    eng_mem_v_i = 0;
    c0 = cyc;
    req(0, 0, AW'(DS + 5), 32'h0, 4'hF, 32'h1234, g, ma, ac);
    chk("stall_accept_cycle", ac, c0);
    idle();

    // Reset while busy with a read pending
    csr_wr(CSR_GO, 32'h1, 4'hF);
    csr_rd(CSR_SIZE, 32'h40);
    idle();
    reset_n_i = 0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_resp_v", rx_returning_v_o, 0);
    chk("mid_rst_go", go_o, 0);
    chk("mid_rst_size", size_o, 0);
    chk("mid_rst_a_addr", a_addr_o, 0);
    @(posedge clk); #1 reset_n_i = 1;
    csr_rd(CSR_DONE, 32'h0);
    csr_rd(CSR_GO, 32'h0);
    idle();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion by 200000");
    $fatal(1);
  end

endmodule
